ps2_key_decoder: RTL and testbench
==================================

# ps2_key_decoder

Scan-code decoder sitting directly downstream of the PS/2 receiver. Consumes one byte per receiver `rx_done_tick`, folds the 0xE0 (extended) and 0xF0 (break) prefixes into a single key event, tracks shift state, and queues complete events in a small show-ahead FIFO for the application logic, which pops them with a read strobe.

## Interface
- `FIFO_DEPTH`, default 4: event FIFO entries; power of two, ≥2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset).
- `rx_done_tick`  in  1  one-cycle strobe from receiver; `rx_data` valid this cycle.
- `rx_data`  in  8  received scan-code byte.
- `key_rd`  in  1  pop head event; honoured only when `key_valid`=1.
- `ovf_clr`  in  1  clears `overflow`.
- `key_valid`  out  1  FIFO non-empty.
- `key_code`  out  8  head event code (0 when empty).
- `key_ext`  out  1  head event had 0xE0 prefix (0 when empty).
- `key_break`  out  1  head event is a release (0 when empty).
- `shift_held`  out  1  left (0x12) or right (0x59) shift currently down.
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full.

## Operation
- FSM states: IDLE, EXT, BRK, EXT_BRK. Advances only on cycles with `rx_done_tick`=1.
- 0xE0 in any state -> EXT; any pending break is discarded.
- 0xF0: IDLE->BRK, EXT->EXT_BRK, BRK/EXT_BRK unchanged.
- Filtered bytes 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF in any state -> IDLE, nothing queued.
- Any other byte -> event {ext = state∈{EXT,EXT_BRK}, brk = state∈{BRK,EXT_BRK}, code = rx_data} written to FIFO; state -> IDLE.
- Shift tracking on non-extended events only: make of 0x12/0x59 sets that bit, break clears it; `shift_held` = OR of both bits. Extended 0x12/0x59 events are queued but do not affect shift.
- FIFO: entries 10 bits {ext, brk, code}; read/write pointers log2(FIFO_DEPTH)+1 bits, wrap naturally; full when MSBs differ and lower bits are equal.
- Full, write, no pop: event dropped, `overflow` set, FIFO unchanged.
- Full, write, pop same cycle: both performed, count unchanged.
- Pop when empty: ignored.
- `overflow`: set beats `ovf_clr` in the same cycle.
- Reset (any time, including mid-prefix): state IDLE, pointers 0, shift bits 0, `overflow` 0; all outputs 0.

## Timing
- Byte strobe at edge N -> FSM/shift/FIFO updated at edge N; `key_valid` and head fields visible after edge N (one-cycle latency from strobe).
- Show-ahead: head fields are valid combinationally whenever `key_valid`=1; `key_rd` at edge M exposes the next entry (or empty) after edge M.
- `shift_held` updates at the same edge as the event write, independent of FIFO fullness (a dropped shift event still updates shift).
- Back-to-back strobes on consecutive cycles are supported.

## Structure
- Package `ps2_pkg`: prefix constants (0xE0, 0xF0), filtered-code list, shift codes (0x12, 0x59), FSM state encoding, event width (10).
- Sub-module `ps2_key_fifo`: synchronous show-ahead FIFO parameterised by depth/width, with full/empty flags. Decoder FSM, shift tracking, and overflow flag live in the top module.

## Test plan
- Strobe 0x1C -> one cycle later `key_valid`=1, `key_code`=0x1C, ext=0, brk=0; `key_rd` -> `key_valid`=0, fields 0.
- Strobes E0, F0, 0x75 -> single event code 0x75, ext=1, brk=1; no events for the prefixes.
- Strobes 0x12 then F0, 0x12 -> `shift_held` 1 after first, 0 after break; two events queued; E0, 0x12 leaves `shift_held` unchanged.
- Strobes 0xFA, 0xAA, F0, 0xFA, 0x1C -> only 0x1C queued, brk=0 (the filtered byte cancels the break).
- Five events with DEPTH=4 and no reads -> fifth dropped, `overflow`=1, FIFO holds first four in order; fifth sent with simultaneous `key_rd` while full -> accepted, no overflow; `ovf_clr` -> 0.
- Strobes E0, F0, then `reset` low, then 0x1C -> all outputs 0 during reset; after release, event 0x1C with ext=0, brk=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, state encoding and event layout for the PS/2 scan-code decoder.
package ps2_pkg;

   localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
   localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
   localparam logic [7:0] PS2_SHIFT_L    = 8'h12;
   localparam logic [7:0] PS2_SHIFT_R    = 8'h59;
   localparam int         EVT_W          = 10;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } ps2_state_t;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_evt_t;

   // Keyboard status/ack bytes that never form part of a key event.
   function automatic logic is_filtered(input logic [7:0] b);
      case (b)
         8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: return 1'b1;
         default:                                   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible combinationally, reads as zero when empty.
module ps2_key_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_wr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd,
   output logic [WIDTH-1:0] o_rd_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;
   logic             w_wr_en;
   logic             w_rd_en;

   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

   // A write while full is still accepted when a pop frees the head slot in the same cycle.
   assign w_rd_en = i_rd && !o_empty;
   assign w_wr_en = i_wr && (!o_full || w_rd_en);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr_en) r_wptr <= r_wptr + 1'b1;
         if (w_rd_en) r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr_en) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
   end

   assign o_rd_data = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/ps2_key_decoder.sv
// Folds E0/F0 prefixes into key events, tracks shift state and queues events for the application.
//
//   state      | meaning
//   -----------+-----------------------------------------------
//   ST_IDLE    | no prefix pending
//   ST_EXT     | 0xE0 seen, next key byte is extended
//   ST_BRK     | 0xF0 seen, next key byte is a release
//   ST_EXT_BRK | 0xE0 then 0xF0 seen, extended release pending
module ps2_key_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done_tick,
   input  logic [7:0] rx_data,
   input  logic       key_rd,
   input  logic       ovf_clr,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_break,
   output logic       shift_held,
   output logic       overflow
);

   ps2_state_t             r_state;
   ps2_state_t             w_state_nxt;
   ps2_evt_t               w_evt;
   logic                   w_evt_wr;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_pop;
   logic                   w_drop;
   logic [EVT_W-1:0]       w_head;
   logic                   r_shift_l;
   logic                   r_shift_r;
   logic                   r_overflow;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_evt_wr    = 1'b0;
      w_evt.ext   = (r_state == ST_EXT) || (r_state == ST_EXT_BRK);
      w_evt.brk   = (r_state == ST_BRK) || (r_state == ST_EXT_BRK);
      w_evt.code  = rx_data;
      if (rx_done_tick) begin
         if (rx_data == PS2_EXT_PREFIX) begin
            w_state_nxt = ST_EXT;
         end else if (rx_data == PS2_BRK_PREFIX) begin
            case (r_state)
               ST_IDLE: w_state_nxt = ST_BRK;
               ST_EXT:  w_state_nxt = ST_EXT_BRK;
               default: w_state_nxt = r_state;
            endcase
         end else if (is_filtered(rx_data)) begin
            w_state_nxt = ST_IDLE;
         end else begin
            w_evt_wr    = 1'b1;
            w_state_nxt = ST_IDLE;
         end
      end
   end

   // Shift follows non-extended make/break even when the event itself is dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift_l <= 1'b0;
         r_shift_r <= 1'b0;
      end else if (w_evt_wr && !w_evt.ext) begin
         if (w_evt.code == PS2_SHIFT_L) r_shift_l <= !w_evt.brk;
         if (w_evt.code == PS2_SHIFT_R) r_shift_r <= !w_evt.brk;
      end
   end

   assign w_pop  = key_rd && !w_empty;
   assign w_drop = w_evt_wr && w_full && !w_pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       r_overflow <= 1'b0;
      else if (w_drop)  r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
   end

   ps2_key_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVT_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (reset),
      .i_wr      (w_evt_wr),
      .i_wr_data (w_evt),
      .i_rd      (key_rd),
      .o_rd_data (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   assign key_valid  = !w_empty;
   assign key_ext    = w_head[9];
   assign key_break  = w_head[8];
   assign key_code   = w_head[7:0];
   assign shift_held = r_shift_l || r_shift_r;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Randomized and directed bench for ps2_key_decoder against a queue-based event model.
module tb_ps2_key_decoder;

   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx_done_tick = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       key_rd = 1'b0;
   logic       ovf_clr = 1'b0;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_break;
   logic       shift_held;
   logic       overflow;

   int n_checks = 0;
   int n_pass   = 0;

   // model: pending-prefix flags, event queue {ext,brk,code}, shift bits, sticky overflow
   bit         m_ext, m_brk, m_shl, m_shr, m_ovf;
   logic [9:0] m_q[$];

   always #5 clk = ~clk;

   ps2_key_decoder #(.FIFO_DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_done_tick (rx_done_tick),
      .rx_data      (rx_data),
      .key_rd       (key_rd),
      .ovf_clr      (ovf_clr),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .key_ext      (key_ext),
      .key_break    (key_break),
      .shift_held   (shift_held),
      .overflow     (overflow)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic bit filtered(input logic [7:0] b);
      return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
   endfunction

   task automatic model_reset();
      m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0; m_ovf = 0;
      m_q.delete();
   endtask

   task automatic model_edge(input bit stb, input logic [7:0] d, input bit rd, input bit clr);
      bit         have_evt = 0;
      bit         pop;
      logic [9:0] evt = '0;
      if (stb) begin
         if (d == 8'hE0) begin
            m_ext = 1; m_brk = 0;
         end else if (d == 8'hF0) begin
            m_brk = 1;
         end else if (filtered(d)) begin
            m_ext = 0; m_brk = 0;
         end else begin
            have_evt = 1;
            evt = {m_ext, m_brk, d};
            if (!m_ext && d == 8'h12) m_shl = !m_brk;
            if (!m_ext && d == 8'h59) m_shr = !m_brk;
            m_ext = 0; m_brk = 0;
         end
      end
      pop = rd && (m_q.size() > 0);
      if (have_evt && m_q.size() == DEPTH && !pop) m_ovf = 1;
      else begin
         if (clr) m_ovf = 0;
         if (pop) void'(m_q.pop_front());
         if (have_evt) m_q.push_back(evt);
      end
   endtask

   task automatic check_all(input string tag);
      logic [9:0] h;
      h = (m_q.size() > 0) ? m_q[0] : 10'h000;
      chk({tag, ".valid"}, 32'(key_valid), 32'(m_q.size() > 0));
      chk({tag, ".code"},  32'(key_code),  32'(h[7:0]));
      chk({tag, ".ext"},   32'(key_ext),   32'(h[9]));
      chk({tag, ".brk"},   32'(key_break), 32'(h[8]));
      chk({tag, ".shift"}, 32'(shift_held), 32'(m_shl || m_shr));
      chk({tag, ".ovf"},   32'(overflow),  32'(m_ovf));
   endtask

   task automatic step(input string tag, input bit stb, input logic [7:0] d,
                       input bit rd, input bit clr);
      @(negedge clk);
      rx_done_tick = stb; rx_data = d; key_rd = rd; ovf_clr = clr;
      @(posedge clk);
      model_edge(stb, d, rd, clr);
      #1;
      check_all(tag);
   endtask

   task automatic key(input string tag, input logic [7:0] d);
      step(tag, 1'b1, d, 1'b0, 1'b0);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < DEPTH + 2 && key_valid; i++) step(tag, 1'b0, 8'h00, 1'b1, 1'b0);
      chk({tag, ".drained"}, 32'(key_valid), 32'd0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b0; rx_done_tick = 0; key_rd = 0; ovf_clr = 0;
      #1;
      model_reset();
      chk({tag, ".rst_valid"}, 32'(key_valid), 32'd0);
      chk({tag, ".rst_code"},  32'(key_code),  32'd0);
      chk({tag, ".rst_ext"},   32'({key_ext, key_break}), 32'd0);
      chk({tag, ".rst_shift"}, 32'(shift_held), 32'd0);
      chk({tag, ".rst_ovf"},   32'(overflow), 32'd0);
      @(posedge clk); #1;
      check_all({tag, ".hold"});
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      model_reset();
      do_reset("por");

      key("make", 8'h1C);
      step("pop", 1'b0, 8'h00, 1'b1, 1'b0);
      step("pop_empty", 1'b0, 8'h00, 1'b1, 1'b0);

      key("e0", 8'hE0); key("f0", 8'hF0); key("ext_brk", 8'h75);
      drain("d1");

      key("shl_make", 8'h12); key("f0b", 8'hF0); key("shl_brk", 8'h12);
      key("shr_make", 8'h59); key("e0s", 8'hE0); key("ext_shl_brk", 8'h12);
      drain("d2");
      key("e0f", 8'hE0); key("f0f", 8'hF0); key("ext_shr_brk", 8'h59);
      key("f0r", 8'hF0); key("shr_brk", 8'h59);
      drain("d3");

      key("fa", 8'hFA); key("aa", 8'hAA); key("f0c", 8'hF0); key("fa2", 8'hFA);
      key("after_filt", 8'h1C);
      drain("d4");

      for (int i = 0; i < 5; i++) key("fill", 8'(8'h20 + i));
      step("full_wr_rd", 1'b1, 8'h30, 1'b1, 1'b0);
      step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b1);
      step("drop_vs_clr", 1'b1, 8'h31, 1'b0, 1'b1);
      drain("d5");
      step("ovf_clr2", 1'b0, 8'h00, 1'b0, 1'b1);

      key("mid_e0", 8'hE0); key("mid_f0", 8'hF0);
      do_reset("midrst");
      key("post_rst", 8'h1C);
      drain("d6");

      for (int i = 0; i < 3000; i++) begin
         logic [7:0] d;
         int         sel;
         sel = int'($urandom_range(0, 99));
         if (sel < 20)      d = 8'hE0;
         else if (sel < 35) d = 8'hF0;
         else if (sel < 45) begin
            logic [7:0] flt [6];
            flt = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
            d = flt[$urandom_range(0, 5)];
         end
         else if (sel < 60) d = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
         else               d = 8'($urandom);
         step("rnd", ($urandom_range(0, 99) < 70), d,
              ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 8));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
